// File: rtl/spi_target_regs.sv
// SPI mode-0 target exposing a 32 x 8 register file to an SPI master and a fabric read port.
// Command byte: [7:3] start address, [1] write flag; data bytes follow with address post-increment.
module spi_target_regs #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       spi_sclk,
    input  logic       spi_ss_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] status_in,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       wr_strobe,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       err_abort
);
    typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
    logic       sclk_prev_q, ss_prev_q;
    logic [1:0] settle_q;
    logic       armed_q;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] miso_sr_q, miso_sr_d;
    logic [4:0] addr_q, addr_d;
    logic       is_write_q, is_write_d;
    logic       load_pend_q, load_pend_d;
    logic       wr_en, abort_d;

    logic [7:0] regs_q [32];
    logic [7:0] rd_data_q;
    logic       wr_strobe_q, err_abort_q;
    logic [4:0] wr_addr_q;
    logic [7:0] wr_data_q;

    logic       sclk_s, ss_s, mosi_s;
    logic       sclk_rise, sclk_fall, ss_fall, ss_rise, settled;
    logic [7:0] rx_byte;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    // A select already low when reset releases must not start a transaction.
    assign ss_fall   = armed_q & ~ss_s & ss_prev_q;
    assign ss_rise   = ss_s & ~ss_prev_q;
    assign settled   = (settle_q == 2'(SYNC_STAGES));
    assign rx_byte   = {shift_q[6:0], mosi_s};

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
            settle_q    <= 2'd0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
            if (!settled) settle_q <= settle_q + 2'd1;
            if (settled && ss_s) armed_q <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        miso_sr_d   = miso_sr_q;
        addr_d      = addr_q;
        is_write_d  = is_write_q;
        load_pend_d = load_pend_q;
        wr_en       = 1'b0;
        abort_d     = 1'b0;
        if (ss_fall) begin
            state_d     = StCmd;
            bit_cnt_d   = 3'd0;
            shift_d     = 8'h00;
            miso_sr_d   = status_in;
            is_write_d  = 1'b0;
            load_pend_d = 1'b0;
        end else if (ss_rise) begin
            abort_d     = (state_q != StIdle) && (bit_cnt_q != 3'd0);
            state_d     = StIdle;
            bit_cnt_d   = 3'd0;
            load_pend_d = 1'b0;
        end else if (state_q != StIdle) begin
            if (sclk_rise) begin
                shift_d   = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (state_q == StCmd) begin
                        state_d     = StData;
                        addr_d      = rx_byte[7:3];
                        is_write_d  = rx_byte[1];
                        load_pend_d = ~rx_byte[1];
                    end else if (is_write_q) begin
                        wr_en  = 1'b1;
                        addr_d = addr_q + 5'd1;
                    end else begin
                        load_pend_d = 1'b1;
                    end
                end
            end else if (sclk_fall) begin
                if (load_pend_q) begin
                    miso_sr_d   = regs_q[addr_q];
                    addr_d      = addr_q + 5'd1;
                    load_pend_d = 1'b0;
                end else begin
                    miso_sr_d = {miso_sr_q[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            miso_sr_q   <= 8'h00;
            addr_q      <= 5'd0;
            is_write_q  <= 1'b0;
            load_pend_q <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 5'd0;
            wr_data_q   <= 8'h00;
            err_abort_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            miso_sr_q   <= miso_sr_d;
            addr_q      <= addr_d;
            is_write_q  <= is_write_d;
            load_pend_q <= load_pend_d;
            wr_strobe_q <= wr_en;
            err_abort_q <= abort_d;
            if (wr_en) begin
                wr_addr_q <= addr_q;
                wr_data_q <= rx_byte;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= 8'h00;
        end else if (wr_en) begin
            regs_q[addr_q] <= rx_byte;
        end
    end

    // Reads the pre-write array, so a same-cycle write to rd_addr returns the old value.
    always_ff @(posedge Clk) begin
        if (!Reset_n) rd_data_q <= 8'h00;
        else          rd_data_q <= regs_q[rd_addr];
    end

    assign spi_miso_oe = ~ss_s;
    assign spi_miso    = spi_miso_oe && (state_q != StIdle) &&
                         !((state_q == StData) && is_write_q) && miso_sr_q[7];
    assign rd_data     = rd_data_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = (state_q != StIdle);
    assign err_abort   = err_abort_q;
endmodule

// File: tb/tb_spi_target_regs.sv
// Directed bench for spi_target_regs: SPI master tasks, a strobe/abort monitor and
// immediate-assertion checks against hand-computed values.
module tb_spi_target_regs;
    logic       Clk = 1'b0;
    logic       Reset_n, spi_sclk, spi_ss_n, spi_mosi, spi_miso, spi_miso_oe;
    logic [7:0] status_in, rd_data, wr_data;
    logic [4:0] rd_addr, wr_addr;
    logic       wr_strobe, busy, err_abort;

    int total = 0;
    int bad = 0;
    int strobe_cnt = 0;
    int abort_cnt = 0;
    logic [4:0] log_addr [$];
    logic [7:0] log_data [$];
    logic [7:0] rd_at_strobe = 8'h00;
    logic [7:0] rd_after = 8'h00;
    logic       grab_next = 1'b0;

    always #10 Clk = ~Clk;

    spi_target_regs #(.SYNC_STAGES(2)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .spi_sclk   (spi_sclk),
        .spi_ss_n   (spi_ss_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .status_in  (status_in),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .err_abort  (err_abort)
    );

    always @(negedge Clk) begin
        if (grab_next) begin
            rd_after  <= rd_data;
            grab_next <= 1'b0;
        end
        if (wr_strobe) begin
            strobe_cnt <= strobe_cnt + 1;
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
            rd_at_strobe <= rd_data;
            grab_next    <= 1'b1;
        end
        if (err_abort) abort_cnt <= abort_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Half SCLK period = 8 Clk cycles, i.e. SCLK = Clk/16.
    task automatic wait_h();
        repeat (8) @(negedge Clk);
    endtask

    task automatic start_xfer();
        spi_ss_n = 1'b0;
        wait_h();
    endtask

    task automatic send_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            wait_h();
            rx[i] = spi_miso;
            spi_sclk = 1'b1;
            wait_h();
            spi_sclk = 1'b0;
        end
    endtask

    task automatic end_xfer();
        wait_h();
        spi_ss_n = 1'b1;
        spi_mosi = 1'b0;
        wait_h();
    endtask

    task automatic read_reg(input logic [4:0] a, output logic [7:0] d);
        @(negedge Clk);
        rd_addr = a;
        @(negedge Clk);
        d = rd_data;
    endtask

    initial begin
        logic [7:0] rx, rd;
        int s0, a0;
        Reset_n = 1'b0;
        spi_sclk = 1'b0;
        spi_ss_n = 1'b1;
        spi_mosi = 1'b0;
        status_in = 8'h00;
        rd_addr = 5'd0;
        repeat (3) @(negedge Clk);
        check("rst_miso", spi_miso, 1'b0);
        check("rst_oe", spi_miso_oe, 1'b0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_wr_strobe", wr_strobe, 1'b0);
        check("rst_wr_addr", wr_addr, 5'd0);
        check("rst_wr_data", wr_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_err_abort", err_abort, 1'b0);
        Reset_n = 1'b1;
        repeat (5) @(negedge Clk);

        // Single write 0x0A,0x5C -> reg 1
        s0 = strobe_cnt;
        start_xfer();
        check("busy_in_xfer", busy, 1'b1);
        check("oe_in_xfer", spi_miso_oe, 1'b1);
        send_bits(8'h0A, 8, rx);
        send_bits(8'h5C, 8, rx);
        end_xfer();
        check("w1_strobe_cnt", strobe_cnt - s0, 1);
        check("w1_addr", log_addr[s0], 5'd1);
        check("w1_data", log_data[s0], 8'h5C);
        check("busy_after", busy, 1'b0);
        read_reg(5'd1, rd);
        check("w1_readback", rd, 8'h5C);

        // Read reg 1 with status 0xA5
        status_in = 8'hA5;
        s0 = strobe_cnt;
        start_xfer();
        send_bits(8'h08, 8, rx);
        check("r1_status", rx, 8'hA5);
        send_bits(8'h00, 8, rx);
        check("r1_data", rx, 8'h5C);
        end_xfer();
        check("r1_no_strobe", strobe_cnt - s0, 0);
        check("idle_oe", spi_miso_oe, 1'b0);
        check("idle_miso", spi_miso, 1'b0);

        // Burst write wrapping 31 -> 0
        s0 = strobe_cnt;
        start_xfer();
        send_bits(8'hFA, 8, rx);
        send_bits(8'h11, 8, rx);
        check("wr_miso_zero", rx, 8'h00);
        send_bits(8'h22, 8, rx);
        end_xfer();
        check("burst_cnt", strobe_cnt - s0, 2);
        check("burst_addr0", log_addr[s0], 5'd31);
        check("burst_data0", log_data[s0], 8'h11);
        check("burst_addr1", log_addr[s0+1], 5'd0);
        check("burst_data1", log_data[s0+1], 8'h22);
        read_reg(5'd31, rd);
        check("reg31", rd, 8'h11);
        read_reg(5'd0, rd);
        check("reg0", rd, 8'h22);

        // Abort after 4 data bits
        s0 = strobe_cnt;
        a0 = abort_cnt;
        start_xfer();
        send_bits(8'h0A, 8, rx);
        send_bits(8'hFF, 4, rx);
        end_xfer();
        check("abort_cnt", abort_cnt - a0, 1);
        check("abort_no_strobe", strobe_cnt - s0, 0);
        read_reg(5'd1, rd);
        check("abort_reg1", rd, 8'h5C);

        // Command-only transaction
        s0 = strobe_cnt;
        a0 = abort_cnt;
        start_xfer();
        send_bits(8'h0A, 8, rx);
        end_xfer();
        check("cmd_only_strobe", strobe_cnt - s0, 0);
        check("cmd_only_abort", abort_cnt - a0, 0);

        // Same-cycle fabric read of reg 3 during SPI write
        start_xfer();
        send_bits(8'h1A, 8, rx);
        send_bits(8'h33, 8, rx);
        end_xfer();
        @(negedge Clk);
        rd_addr = 5'd3;
        start_xfer();
        send_bits(8'h1A, 8, rx);
        send_bits(8'hC4, 8, rx);
        end_xfer();
        check("rdw_old", rd_at_strobe, 8'h33);
        check("rdw_new", rd_after, 8'hC4);

        // Reset mid-burst, with SS_n held low across release
        start_xfer();
        send_bits(8'h22, 8, rx);
        send_bits(8'hAA, 8, rx);
        send_bits(8'hBB, 8, rx);
        send_bits(8'hCC, 4, rx);
        s0 = strobe_cnt;
        a0 = abort_cnt;
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst2_busy", busy, 1'b0);
        check("rst2_oe", spi_miso_oe, 1'b0);
        Reset_n = 1'b1;
        wait_h();
        send_bits(8'h12, 8, rx);
        send_bits(8'h77, 8, rx);
        check("stale_ss_busy", busy, 1'b0);
        end_xfer();
        check("rst2_no_strobe", strobe_cnt - s0, 0);
        check("rst2_no_abort", abort_cnt - a0, 0);
        for (int i = 0; i < 32; i++) begin
            read_reg(5'(i), rd);
            check($sformatf("rst2_reg%0d", i), rd, 8'h00);
        end
        s0 = strobe_cnt;
        start_xfer();
        send_bits(8'h12, 8, rx);
        send_bits(8'h77, 8, rx);
        end_xfer();
        check("post_rst_cnt", strobe_cnt - s0, 1);
        check("post_rst_addr", log_addr[s0], 5'd2);
        check("post_rst_data", log_data[s0], 8'h77);
        read_reg(5'd2, rd);
        check("post_rst_reg2", rd, 8'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
